// File: rtl/izhikevich_synapse.sv
// Spike-receiving synapse producing the input current of an Izhikevich neuron.
// Spikes arrive on a valid/ready handshake into a 4-deep index FIFO. Each time
// step decays the current by DECAY, then adds the weight of every queued spike
// in arrival order, one float32 add per cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   spike_valid/idx   offered spike and its presynaptic index (selects W0..W3)
//   spike_ready       FIFO accepts a spike this cycle
//   step              one-cycle pulse advancing one time step
//   i_syn             synaptic current (float32), registered
//   i_valid           one-cycle pulse: i_syn holds a completed step
//   busy              step in progress
//   step_ovf          sticky: a step request was dropped
module izhikevich_synapse #(
   parameter logic [31:0] W0    = 32'h3F800000,
   parameter logic [31:0] W1    = 32'h3F800000,
   parameter logic [31:0] W2    = 32'h3F800000,
   parameter logic [31:0] W3    = 32'h3F800000,
   parameter logic [31:0] DECAY = 32'h3F666666
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spike_valid,
   input  logic [1:0]  spike_idx,
   output logic        spike_ready,
   input  logic        step,
   output logic [31:0] i_syn,
   output logic        i_valid,
   output logic        busy,
   output logic        step_ovf
);

   // Round-to-nearest-even and pack. m carries the hidden bit at [23] and a
   // spare carry bit at [24]; results below the normal range flush to zero.
   function automatic logic [31:0] fpack(input logic s, input logic signed [9:0] e_in,
                                         input logic [24:0] m_in, input logic g,
                                         input logic st);
      logic signed [9:0] e;
      logic [24:0]       m;
      e = e_in;
      m = m_in;
      if (g && (st || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 10'sd1;
      end
      if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
      if (e <= 10'sd0 || !m[23]) return {s, 31'h0};
      return {s, e[7:0], m[22:0]};
   endfunction

   // Float32 multiply (combinational).
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic              s;
      logic [47:0]       p;
      logic signed [9:0] e;
      s = a[31] ^ b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
         return 32'h7FC00000;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
         return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (p[47])
         return fpack(s, e + 10'sd1, {1'b0, p[47:24]}, p[23], |p[22:0]);
      return fpack(s, e, {1'b0, p[46:23]}, p[22], |p[21:0]);
   endfunction

   // Float32 add (combinational). Three extra low bits hold guard/round/sticky.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]       x, y;
      logic [7:0]        d;
      logic [26:0]       mx, my, r;
      logic [53:0]       sh;
      logic [27:0]       sum;
      logic [4:0]        lz;
      logic signed [9:0] e;
      if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
         return 32'h7FC00000;
      if (a[30:23] == 8'hFF)
         return (b[30:23] == 8'hFF && a[31] != b[31]) ? 32'h7FC00000 : a;
      if (b[30:23] == 8'hFF) return b;
      if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'h0} : b;
      if (b[30:23] == 8'h00) return a;
      // x is the operand of larger magnitude; the result takes its sign
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      if (d >= 8'd27) my = 27'd1;
      else begin
         sh = {my, 27'h0} >> d;
         my = {sh[53:28], sh[27] | (|sh[26:0])};
      end
      e = $signed({2'b00, x[30:23]});
      if (x[31] == y[31]) begin
         sum = {1'b0, mx} + {1'b0, my};
         if (sum[27]) begin
            r = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
         end else r = sum[26:0];
      end else begin
         r = mx - my;
         if (r == 27'h0) return 32'h0;
         lz = 5'd0;
         for (int i = 0; i < 27; i++) if (r[i]) lz = 5'(26 - i);
         r = r << lz;
         e = e - $signed({5'b00000, lz});
      end
      return fpack(x[31], e, {1'b0, r[26:3]}, r[2], r[1] | r[0]);
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_DECAY, S_DRAIN, S_DONE} state_t;

   state_t      state;
   logic [1:0]  fifo [4];
   logic [1:0]  wp, rp;
   logic [2:0]  cnt;
   logic        pending;
   logic        push, pop;
   logic [31:0] w_head, prod, sum;

   assign spike_ready = rst && (cnt != 3'd4) && (state != S_DRAIN);
   assign push        = spike_valid && spike_ready;
   assign pop         = (state == S_DRAIN);
   assign busy        = (state != S_IDLE);

   always_comb begin
      case (fifo[rp])
         2'd0:    w_head = W0;
         2'd1:    w_head = W1;
         2'd2:    w_head = W2;
         default: w_head = W3;
      endcase
   end

   assign prod = fmul(i_syn, DECAY);
   assign sum  = fadd(i_syn, w_head);

   // Index storage needs no reset: it is only read behind a nonzero count.
   always_ff @(posedge clk) begin
      if (push) fifo[wp] <= spike_idx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         wp       <= 2'd0;
         rp       <= 2'd0;
         cnt      <= 3'd0;
         pending  <= 1'b0;
         step_ovf <= 1'b0;
         i_syn    <= 32'h0;
         i_valid  <= 1'b0;
      end else begin
         i_valid <= 1'b0;
         // One step may wait behind the running one; a further one is lost.
         // A step arriving in IDLE together with a pending one stays pending.
         if (state == S_IDLE) pending <= step && pending;
         else if (step) begin
            if (pending) step_ovf <= 1'b1;
            else         pending  <= 1'b1;
         end
         case (state)
            S_IDLE: if (step || pending) state <= S_DECAY;
            S_DECAY: begin
               i_syn <= prod;
               if (cnt != 3'd0) state <= S_DRAIN;
               else begin
                  state   <= S_DONE;
                  i_valid <= 1'b1;
               end
            end
            // Pushes are blocked here, so the count at entry fixes the length.
            S_DRAIN: begin
               i_syn <= sum;
               rp    <= rp + 2'd1;
               if (cnt == 3'd1) begin
                  state   <= S_DONE;
                  i_valid <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (push) wp <= wp + 2'd1;
         cnt <= cnt + {2'b00, push} - {2'b00, pop};
      end
   end

endmodule

// File: tb/tb_izhikevich_synapse.sv
// Self-checking bench for izhikevich_synapse: directed scenarios followed by
// randomized spikes/steps/resets, every cycle compared against a queue-and-real
// reference model of the synapse.
module tb_izhikevich_synapse;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        spike_valid = 1'b0;
   logic [1:0]  spike_idx = 2'd0;
   logic        step = 1'b0;
   logic        spike_ready, i_valid, busy, step_ovf;
   logic [31:0] i_syn;

   izhikevich_synapse #(
      .W0(32'h3F800000), .W1(32'h40000000), .W2(32'hBF800000), .W3(32'h40400000),
      .DECAY(32'h3F000000)
   ) dut (
      .clk(clk), .rst(rst), .spike_valid(spike_valid), .spike_idx(spike_idx),
      .spike_ready(spike_ready), .step(step), .i_syn(i_syn), .i_valid(i_valid),
      .busy(busy), .step_ovf(step_ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: queued spike indices, current as a real, and the
   // progress of the step in flight.
   real w [4] = '{1.0, 2.0, -1.0, 3.0};
   int  q[$];
   real acc = 0.0;
   bit  m_decay, m_drain, m_done, m_pend, m_ovf;

   logic        obs_valid, obs_ready, obs_ovf;
   logic [31:0] obs_syn;

   // Exact for the values this bench produces (few fraction bits).
   function automatic logic [31:0] to_f32(input real v);
      real        a;
      int         e;
      logic       s;
      logic [22:0] f;
      if (v == 0.0) return 32'h0;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 127;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      f = 23'($rtoi((a - 1.0) * 8388608.0));
      return {s, 8'(e), f};
   endfunction

   function automatic bit m_busy();
      return m_decay || m_drain || m_done;
   endfunction

   function automatic bit exp_ready();
      return rst && (q.size() < 4) && !m_drain;
   endfunction

   task automatic m_reset();
      q.delete();
      acc = 0.0;
      m_decay = 0; m_drain = 0; m_done = 0; m_pend = 0; m_ovf = 0;
   endtask

   // Advance the model across one rising edge with the inputs now driven.
   task automatic m_edge();
      bit was_busy, took, had;
      if (!rst) return;
      was_busy = m_busy();
      took     = spike_valid && exp_ready();
      had      = (q.size() > 0);
      if (m_done) m_done = 0;
      else if (m_drain) begin
         acc = acc + w[q.pop_front()];
         if (q.size() == 0) begin m_drain = 0; m_done = 1; end
      end else if (m_decay) begin
         acc = acc * 0.5;
         m_decay = 0;
         if (had) m_drain = 1; else m_done = 1;
      end
      if (!was_busy) begin
         if (step || m_pend) begin
            m_decay = 1;
            m_pend  = step && m_pend;
         end
      end else if (step) begin
         if (m_pend) m_ovf = 1; else m_pend = 1;
      end
      if (took) q.push_back(int'(spike_idx));
   endtask

   // One clock cycle: drive, compare at the falling edge, step the model.
   task automatic tick(input bit sv, input logic [1:0] idx, input bit st);
      spike_valid = sv;
      spike_idx   = idx;
      step        = st;
      if (!rst) m_reset();
      @(negedge clk);
      obs_valid = i_valid;
      obs_ready = spike_ready;
      obs_ovf   = step_ovf;
      obs_syn   = i_syn;
      chk("spike_ready", 32'(spike_ready), 32'(exp_ready()));
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("i_valid", 32'(i_valid), 32'(m_done));
      chk("i_syn", i_syn, to_f32(acc));
      chk("step_ovf", 32'(step_ovf), 32'(m_ovf));
      m_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nv;
      int until_rst;

      // Reset held for three cycles
      rst = 1'b0;
      repeat (3) tick(0, 2'd0, 0);
      chk("rst_ready", 32'(obs_ready), 32'd0);
      chk("rst_syn", obs_syn, 32'h0);
      rst = 1'b1;
      tick(0, 2'd0, 0);
      chk("post_rst_ready", 32'(obs_ready), 32'd1);

      // Basic accumulation: 1.0 + 2.0
      tick(1, 2'd0, 0);
      tick(1, 2'd1, 0);
      tick(0, 2'd0, 1);
      nv = 0;
      repeat (3) begin tick(0, 2'd0, 0); if (obs_valid) nv++; end
      chk("basic_early_valid", 32'(nv), 32'd0);
      tick(0, 2'd0, 0);
      chk("basic_valid", 32'(obs_valid), 32'd1);
      chk("basic_syn", obs_syn, 32'h40400000);

      // Decay only
      tick(0, 2'd0, 1);
      tick(0, 2'd0, 0);
      tick(0, 2'd0, 0);
      chk("decay_valid", 32'(obs_valid), 32'd1);
      chk("decay_syn", obs_syn, 32'h3FC00000);

      // Full FIFO; the fifth spike is held until the DONE cycle
      repeat (4) tick(1, 2'd3, 0);
      tick(1, 2'd3, 0);
      chk("full_ready", 32'(obs_ready), 32'd0);
      tick(1, 2'd3, 1);
      repeat (6) tick(1, 2'd3, 0);
      chk("full_valid", 32'(obs_valid), 32'd1);
      chk("full_syn", obs_syn, 32'h414C0000);
      chk("full_done_ready", 32'(obs_ready), 32'd1);

      // Step during DRAIN is serviced after returning to IDLE
      tick(1, 2'd1, 0);
      tick(1, 2'd2, 0);
      tick(0, 2'd0, 1);
      tick(0, 2'd0, 0);
      tick(0, 2'd0, 1);
      repeat (3) tick(0, 2'd0, 0);
      chk("pend_first_syn", obs_syn, 32'h41260000);
      tick(0, 2'd0, 0);
      tick(0, 2'd0, 0);
      tick(0, 2'd0, 0);
      chk("pend_second_valid", 32'(obs_valid), 32'd1);
      chk("pend_second_syn", obs_syn, 32'h40A60000);

      // Two steps during one DRAIN: one is dropped
      repeat (3) tick(1, 2'd0, 0);
      tick(0, 2'd0, 1);
      tick(0, 2'd0, 0);
      tick(0, 2'd0, 1);
      tick(0, 2'd0, 1);
      tick(0, 2'd0, 0);
      chk("ovf_set", 32'(obs_ovf), 32'd1);
      repeat (6) tick(0, 2'd0, 0);
      chk("ovf_sticky", 32'(obs_ovf), 32'd1);

      // Reset in the second DRAIN cycle
      tick(1, 2'd0, 0);
      tick(1, 2'd1, 0);
      tick(1, 2'd3, 0);
      tick(0, 2'd0, 1);
      tick(0, 2'd0, 0);
      tick(0, 2'd0, 0);
      rst = 1'b0;
      tick(0, 2'd0, 0);
      chk("abort_syn", obs_syn, 32'h0);
      chk("abort_valid", 32'(obs_valid), 32'd0);
      chk("abort_ovf", 32'(obs_ovf), 32'd0);
      tick(0, 2'd0, 0);
      rst = 1'b1;
      tick(0, 2'd0, 1);
      tick(0, 2'd0, 0);
      tick(0, 2'd0, 0);
      chk("abort_step_valid", 32'(obs_valid), 32'd1);
      chk("abort_step_syn", obs_syn, 32'h0);

      // Randomized traffic with periodic resets, checked every cycle
      until_rst = 30;
      for (int c = 0; c < 2000; c++) begin
         if (until_rst == 0) begin
            rst = 1'b0;
            until_rst = $urandom_range(45, 20);
         end else begin
            rst = 1'b1;
            until_rst--;
         end
         tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/izhikevich_synapse.md
# izhikevich_synapse

Spike-receiving synapse that feeds the input-current operand of an Izhikevich neuron. It accepts spike events from presynaptic neurons over a valid/ready handshake and queues them in a 4-entry FIFO. On each simulation time step it decays the synaptic current and adds the weight of every queued spike, all in IEEE-754 single precision using the existing `_fmultp_`/`_fadder_` float units. Its `i_syn` output connects directly to a neuron's `in` input.

## Interface
- `W0`, default 32'h3F800000 (1.0): weight added for spike index 0.
- `W1`, default 32'h3F800000: weight added for spike index 1.
- `W2`, default 32'h3F800000: weight added for spike index 2.
- `W3`, default 32'h3F800000: weight added for spike index 3.
- `DECAY`, default 32'h3F666666 (0.9): per-step multiplicative decay, equal to 1 − dt/tau.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low (resets while 0).
- `spike_valid`  in  1  spike event offered.
- `spike_idx`  in  2  presynaptic index of the offered spike; selects W0..W3.
- `spike_ready`  out  1  FIFO can accept a spike this cycle.
- `step`  in  1  one-cycle pulse that advances one time step.
- `i_syn`  out  32  synaptic current (float32), registered.
- `i_valid`  out  1  one-cycle pulse: `i_syn` holds the result of a completed step.
- `busy`  out  1  FSM not in IDLE.
- `step_ovf`  out  1  sticky flag: a step was dropped. Cleared only by reset.

## Operation
- **Spike handshake:** a spike is pushed when `spike_valid & spike_ready` at a rising edge. `spike_idx` is captured into the FIFO.
- **spike_ready:** equals `!full && state != DRAIN`. It is 0 while `rst` = 0.
- **FSM states:** IDLE, DECAY, DRAIN, DONE.
- **IDLE:**
  - If `step` or a pending step is present, go to DECAY and clear the pending bit.
- **DECAY (1 cycle):**
  - `i_syn <= i_syn * DECAY`.
  - If the FIFO is non-empty, go to DRAIN; otherwise go to DONE.
- **DRAIN (1 cycle per entry):**
  - Pop the head entry and update `i_syn <= i_syn + W[head]`.
  - Leave for DONE in the cycle the last entry is popped.
  - No pushes are accepted, so the drain length is fixed at entry.
- **DONE (1 cycle):** `i_valid` = 1, then go to IDLE.
- **Accumulation order:** FIFO order, one add per cycle. Float addition is non-associative, so reordering is not permitted.
- **Step while busy:**
  - A `step` arriving while `busy` = 1 sets the pending bit.
  - A `step` arriving while pending is already set is dropped and sets `step_ovf`.
  - A `step` in the IDLE cycle is taken directly.
- **Simultaneous events:**
  - A push and `step` in the same IDLE cycle: the pushed spike is included in that step.
  - A push while FIFO is full: not accepted, because `spike_ready` = 0 and the source holds.
- **FIFO pointers:** 2-bit read/write pointers wrap modulo 4, plus a 3-bit count. Full means count = 4; empty means count = 0.
- **NaN, Inf and denormals:** passed through as the float units produce them. No special handling.
- **Reset (any state, including mid-DRAIN):**
  - Aborts immediately: state IDLE, FIFO empty, pending = 0, `step_ovf` = 0.
  - No `i_valid` pulse is emitted for the aborted step.

## Timing
- **Reset values:** `i_syn` = 32'h00000000, `i_valid` = 0, `busy` = 0, `step_ovf` = 0, `spike_ready` = 0 while `rst` = 0. `spike_ready` = 1 in the first cycle after `rst` releases.
- **Step latency** (for `step` sampled at edge k with N queued spikes):
  - DECAY occupies cycle k+1.
  - DRAIN occupies cycles k+2 .. k+1+N.
  - `i_valid` = 1 in cycle k+2+N, meaning visible after edge k+1+N.
  - IDLE from cycle k+3+N.
- **`i_syn` stability:** it changes only on DECAY/DRAIN edges and is stable while `i_valid` = 1 and throughout IDLE.
- **Throughput:** at most one step per N+3 cycles; one spike accepted per cycle when not full and not draining.
- **Float units:** `_fmultp_` and `_fadder_` are combinational; each result must settle within one clock.

## Test plan
Bench parameters: W0 = 1.0 (3F800000), W1 = 2.0 (40000000), W2 = −1.0 (BF800000), W3 = 3.0 (40400000), DECAY = 0.5 (3F000000).

1. **Reset:** hold `rst` = 0 for 3 cycles, then release. Required: `i_syn` = 0, `i_valid` = 0, `busy` = 0, `spike_ready` 0 during reset and 1 after.
2. **Basic accumulation:** push idx0, then idx1, then pulse `step`. Required: `i_valid` pulses exactly once, 4 cycles after `step`, with `i_syn` = 40400000 (3.0).
3. **Decay only:** continue from scenario 2 and pulse `step` with the FIFO empty. Required: `i_valid` 2 cycles later, `i_syn` = 3FC00000 (1.5).
4. **Full FIFO:** continue from scenario 3.
   - Push idx3 four times; `spike_ready` = 0 and the 5th spike is held.
   - Pulse `step`. Required: `i_syn` = 414C0000 (12.75).
   - The 5th spike is accepted in the DONE cycle and is included in the next step.
5. **Step while busy:**
   - Pulse `step` during DRAIN. Required: pending bit serviced, i.e. a second `i_valid` follows in the cycle after returning to IDLE + 2.
   - Pulse `step` twice during one DRAIN. Required: `step_ovf` = 1 and it stays 1.
6. **Reset mid-DRAIN:** assert `rst` = 0 during the second DRAIN cycle. Required: `i_syn` = 0 immediately, FIFO empty, no `i_valid` pulse, and a later `step` yields `i_syn` = 0.
